multiword_add_ctrl: RTL

MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

---
 rtl/multiword_add_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/multiword_add_ctrl.sv
// multiword_add_ctrl
//   Multi-limb add/subtract controller. One 32-bit ripple adder is reused
//   across WORDS limbs, least significant limb first, one limb per clock.
//   Subtraction is a + ~b + 1: the b limbs are inverted and the carry
//   register is seeded with sub.
//
// Ports
//   clk      : single clock, rising edge
//   rst_n    : synchronous active-low reset
//   start    : begin an operation (sampled only in IDLE or DONE)
//   sub      : 0 = a+b, 1 = a-b
//   a, b     : operands, 32*WORDS bits
//   sum      : registered result
//   cout     : carry out of the top limb (sub: 1 = no borrow)
//   overflow : two's-complement overflow of the full-width result
//   busy     : high while limbs are being computed (RUN)
//   done     : one-cycle completion pulse (DONE)
//
// state | meaning
// ------+---------------------------------------------------
// IDLE  | waiting for start
// RUN   | one limb per cycle through the shared adder
// DONE  | result complete, done high; start here restarts RUN

module ripple_carry_addr_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        co
);
    logic w_c;

    always_comb begin
        s   = '0;
        w_c = cin;
        for (int i = 0; i < 32; i++) begin
            s[i] = a[i] ^ b[i] ^ w_c;
            w_c  = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
        end
        co = w_c;
    end
endmodule

module multiword_add_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sub,
    input  logic [32*WORDS-1:0] a,
    input  logic [32*WORDS-1:0] b,
    output logic [32*WORDS-1:0] sum,
    output logic                cout,
    output logic                overflow,
    output logic                busy,
    output logic                done
);
    localparam int W     = 32 * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_sub;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [W-1:0]     r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [31:0]      w_a_limb;
    logic [31:0]      w_b_limb;
    logic [31:0]      w_add_s;
    logic             w_add_co;
    logic             w_last;
    logic             w_accept;
    logic             w_bp_msb;

    // Limb offset is idx*32, formed by concatenation to keep widths exact.
    assign w_a_limb = r_a[{r_idx, 5'b0} +: 32];
    assign w_b_limb = r_b[{r_idx, 5'b0} +: 32] ^ {32{r_sub}};
    assign w_last   = (r_idx == IDX_W'(WORDS - 1));
    assign w_accept = start && (r_state != S_RUN);
    assign w_bp_msb = r_b[W-1] ^ r_sub;

    ripple_carry_addr_32 u_add (
        .a   (w_a_limb),
        .b   (w_b_limb),
        .cin (r_carry),
        .s   (w_add_s),
        .co  (w_add_co)
    );

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = start ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_sub   <= sub;
                r_idx   <= '0;
                r_carry <= sub;
            end else if (r_state == S_RUN) begin
                r_sum[{r_idx, 5'b0} +: 32] <= w_add_s;
                r_carry <= w_add_co;
                if (w_last) begin
                    r_idx  <= '0;
                    r_cout <= w_add_co;
                    // Sign of the result is the top bit of the final limb.
                    r_ovf  <= (r_a[W-1] == w_bp_msb) && (w_add_s[31] != r_a[W-1]);
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;
endmodule
